// File: rtl/vpu_src_port_if.sv
// Bundle of the vpu_src_port command, SRAM read and operand-issue signals.
// slave is the operand-fetch block's view; master is the controller/SRAM/FP-unit side.
interface vpu_src_port_if #(
  parameter int OPERAND_WIDTH   = 16,
  parameter int SRAM_R_PORT_CNT = 3,
  parameter int ADDR_WIDTH      = 10,
  parameter int LEN_WIDTH       = 10
);
  logic                       cmd_valid_i;
  logic                       cmd_ready_o;
  logic [SRAM_R_PORT_CNT-1:0] cmd_mask_i;
  logic [ADDR_WIDTH-1:0]      cmd_addr0_i;
  logic [ADDR_WIDTH-1:0]      cmd_addr1_i;
  logic [ADDR_WIDTH-1:0]      cmd_addr2_i;
  logic [LEN_WIDTH-1:0]       cmd_len_i;
  logic [SRAM_R_PORT_CNT-1:0] sram_rd_en_o;
  logic [ADDR_WIDTH-1:0]      sram_rd_addr0_o;
  logic [ADDR_WIDTH-1:0]      sram_rd_addr1_o;
  logic [ADDR_WIDTH-1:0]      sram_rd_addr2_o;
  logic [OPERAND_WIDTH-1:0]   sram_rd_data0_i;
  logic [OPERAND_WIDTH-1:0]   sram_rd_data1_i;
  logic [OPERAND_WIDTH-1:0]   sram_rd_data2_i;
  logic [OPERAND_WIDTH-1:0]   op_0;
  logic [OPERAND_WIDTH-1:0]   op_1;
  logic [OPERAND_WIDTH-1:0]   op_2;
  logic                       start_o;
  logic [SRAM_R_PORT_CNT-1:0] op_valid_o;
  logic                       done_o;

  modport slave (
    input  cmd_valid_i, cmd_mask_i, cmd_addr0_i, cmd_addr1_i, cmd_addr2_i, cmd_len_i,
    input  sram_rd_data0_i, sram_rd_data1_i, sram_rd_data2_i,
    output cmd_ready_o, sram_rd_en_o, sram_rd_addr0_o, sram_rd_addr1_o, sram_rd_addr2_o,
    output op_0, op_1, op_2, start_o, op_valid_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_mask_i, cmd_addr0_i, cmd_addr1_i, cmd_addr2_i, cmd_len_i,
    output sram_rd_data0_i, sram_rd_data1_i, sram_rd_data2_i,
    input  cmd_ready_o, sram_rd_en_o, sram_rd_addr0_o, sram_rd_addr1_o, sram_rd_addr2_o,
    input  op_0, op_1, op_2, start_o, op_valid_o, done_o
  );
endinterface

// File: rtl/vpu_src_port.sv
// Operand-fetch front end: takes one vector command, streams element reads
// from up to three SRAM read ports, realigns the returned data through a
// read-latency delay line and issues operands with a one-cycle start strobe.
// Illegal or empty commands pass through DRAIN (pipeline already empty) so
// their done pulse lands two cycles after acceptance.
module vpu_src_port #(
  parameter int OPERAND_WIDTH   = 16,
  parameter int SRAM_R_PORT_CNT = 3,
  parameter int ADDR_WIDTH      = 10,
  parameter int LEN_WIDTH       = 10,
  parameter int SRAM_RD_LAT     = 1
) (
  input logic           clk,
  input logic           rst,
  vpu_src_port_if.slave bus
);

  localparam int NP = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state_r;
  state_t                     state_s;
  logic [SRAM_R_PORT_CNT-1:0] mask_r;
  logic [ADDR_WIDTH-1:0]      base_r [NP];
  logic [LEN_WIDTH-1:0]       len_r;
  logic [LEN_WIDTH-1:0]       idx_r;
  logic [SRAM_RD_LAT-1:0]     pipe_r;
  logic [OPERAND_WIDTH-1:0]   op_r [NP];
  logic                       start_r;

  logic [OPERAND_WIDTH-1:0]   rd_data_s [NP];
  logic [ADDR_WIDTH-1:0]      rd_addr_s [NP];
  logic [SRAM_R_PORT_CNT-1:0] rd_en_s;
  logic                       accept_s;
  logic                       legal_s;
  logic                       issue_s;
  logic                       last_s;
  logic                       drained_s;

  assign rd_data_s[0] = bus.sram_rd_data0_i;
  assign rd_data_s[1] = bus.sram_rd_data1_i;
  assign rd_data_s[2] = bus.sram_rd_data2_i;

  assign accept_s  = (state_r == IDLE) && bus.cmd_valid_i;
  assign legal_s   = (bus.cmd_len_i != {LEN_WIDTH{1'b0}}) && bus.cmd_mask_i[0] && bus.cmd_mask_i[1];
  assign issue_s   = (state_r == ISSUE);
  assign last_s    = (idx_r == (len_r - LEN_WIDTH'(1'b1)));
  assign drained_s = (pipe_r == {SRAM_RD_LAT{1'b0}});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          state_s = legal_s ? ISSUE : DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_s) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (drained_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Command latch and element index; the mask is dropped on the way back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r <= {SRAM_R_PORT_CNT{1'b0}};
      len_r  <= {LEN_WIDTH{1'b0}};
      idx_r  <= {LEN_WIDTH{1'b0}};
      for (int p = 0; p < NP; p++) begin
        base_r[p] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (accept_s) begin
      mask_r    <= bus.cmd_mask_i;
      len_r     <= bus.cmd_len_i;
      idx_r     <= {LEN_WIDTH{1'b0}};
      base_r[0] <= bus.cmd_addr0_i;
      base_r[1] <= bus.cmd_addr1_i;
      base_r[2] <= bus.cmd_addr2_i;
    end else begin
      if (issue_s) begin
        idx_r <= idx_r + LEN_WIDTH'(1'b1);
      end
      if (state_r == DONE) begin
        mask_r <= {SRAM_R_PORT_CNT{1'b0}};
      end
    end
  end

  // Issue-flag delay line matching the SRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_r <= {SRAM_RD_LAT{1'b0}};
    end else begin
      pipe_r[0] <= issue_s;
      for (int k = 1; k < SRAM_RD_LAT; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  // Capture returned data as the flag leaves the delay line; operands hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r <= 1'b0;
      for (int p = 0; p < NP; p++) begin
        op_r[p] <= {OPERAND_WIDTH{1'b0}};
      end
    end else begin
      start_r <= pipe_r[SRAM_RD_LAT-1];
      if (pipe_r[SRAM_RD_LAT-1]) begin
        for (int p = 0; p < NP; p++) begin
          op_r[p] <= mask_r[p] ? rd_data_s[p] : {OPERAND_WIDTH{1'b0}};
        end
      end
    end
  end

  // Read enables and addresses (base + idx, wrapping) during ISSUE only.
  always_comb begin
    rd_en_s = issue_s ? mask_r : {SRAM_R_PORT_CNT{1'b0}};
    for (int p = 0; p < NP; p++) begin
      if (issue_s && mask_r[p]) begin
        rd_addr_s[p] = base_r[p] + ADDR_WIDTH'(idx_r);
      end else begin
        rd_addr_s[p] = {ADDR_WIDTH{1'b0}};
      end
    end
  end

  assign bus.cmd_ready_o     = (state_r == IDLE);
  assign bus.sram_rd_en_o    = rd_en_s;
  assign bus.sram_rd_addr0_o = rd_addr_s[0];
  assign bus.sram_rd_addr1_o = rd_addr_s[1];
  assign bus.sram_rd_addr2_o = rd_addr_s[2];
  assign bus.op_0            = op_r[0];
  assign bus.op_1            = op_r[1];
  assign bus.op_2            = op_r[2];
  assign bus.start_o         = start_r;
  assign bus.op_valid_o      = mask_r;
  assign bus.done_o          = (state_r == DONE);

endmodule
